hamming_dec: RTL and testbench
==============================

HAMMING_DEC -- requirements
Module: hamming_dec

Interface
REQ-001 SHALL have parameter k, default 4, data width in bits.
REQ-002 SHALL have parameter m, default 3, parity width in bits; k+m <= 2**m - 1.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port cin  input  k+m  received codeword {parity[m-1:0], data[k-1:0]}.
REQ-006 SHALL have port cvld  input  1  cin valid.
REQ-007 SHALL have port crdy  output  1  decoder accepts cin this cycle.
REQ-008 SHALL have port dout  output  k  corrected data.
REQ-009 SHALL have port dvld  output  1  dout valid.
REQ-010 SHALL have port drdy  input  1  downstream accepts dout.
REQ-011 SHALL have port syn  output  m  syndrome of the word on dout.
REQ-012 SHALL have port err_corr  output  1  single-bit error corrected, qualified by dvld.
REQ-013 SHALL have port err_uncorr  output  1  syndrome out of range, uncorrectable, qualified by dvld.
REQ-014 SHALL have port corr_cnt  output  16  count of delivered words with err_corr.
REQ-015 SHALL have port uncorr_cnt  output  16  count of delivered words with err_uncorr.

Function
REQ-016 SHALL use placed codeword positions p=0..k+m-1; data bits fill positions where p+1 is not a power of two, ascending, data[0] first; parity[i] sits at p=2**i-1.
REQ-017 SHALL compute syn[i] = received parity[i] XOR (XOR of all placed data bits at p where bit i of p+1 is set).
REQ-018 SHALL be a 2-stage pipeline: stage 1 registers cin and syndrome; stage 2 registers corrected data and flags; latency 2 cycles with no stall.
REQ-019 SHALL advance both stages together when adv = !dvld || drdy; crdy = adv; cin captured on cvld && crdy.
REQ-020 SHALL hold dout, dvld, syn and flags stable while dvld && !drdy.
REQ-021 SHALL, when syn==0: dout = data, err_corr=0, err_uncorr=0.
REQ-022 SHALL, when syn is a power of two: dout = data unchanged (parity-bit error), err_corr=1.
REQ-023 SHALL, when syn is not a power of two and syn <= k+m: invert the data bit placed at p = syn-1, err_corr=1.
REQ-024 SHALL, when syn > k+m: dout = data unchanged, err_uncorr=1, err_corr=0.
REQ-025 SHALL drain stage 1 with a bubble (stage-1 valid=0) when adv && !cvld; bubbles never raise dvld.
REQ-026 SHALL increment corr_cnt / uncorr_cnt by 1 on each handshake dvld && drdy with the flag set; saturate at 16'hFFFF.
REQ-027 SHALL never complete a handshake twice for one word; a stalled word counts once.

Reset
REQ-028 SHALL, while rst=1, force dvld=0, both stage valids=0, dout=0, syn=0, err_corr=0, err_uncorr=0, corr_cnt=0, uncorr_cnt=0, crdy=1.
REQ-029 SHALL discard any in-flight words on rst assertion mid-stream; no partial output after release.
REQ-030 SHALL accept cin on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL pass: k=4,m=3, cin=7'b0011011, cvld=1, drdy=1 -> 2 cycles later dout=4'b1011, syn=0, no flags.
REQ-032 SHALL pass: cin=7'b0011111 (data[2] flipped) -> dout=4'b1011, syn=3'b110, err_corr=1, corr_cnt=1.
REQ-033 SHALL pass: cin=7'b0111011 (parity[1] flipped) -> dout=4'b1011, syn=3'b010, err_corr=1.
REQ-034 SHALL pass: k=3,m=3, cin=6'b100001 -> syn=3'b111, err_uncorr=1, dout=3'b001, uncorr_cnt=1.
REQ-035 SHALL pass: back-to-back words, drdy=0 for 3 cycles -> crdy=0 while both stages full, dout held, no loss or duplication, order preserved, counters incremented once per word.
REQ-036 SHALL pass: rst pulsed with 2 words in flight -> dvld=0 immediately, counters 0, next word out 2 cycles after acceptance.

Source files
------------

// File: rtl/hamming_dec.sv
// hamming_dec: two-stage pipelined Hamming single-error-correcting decoder
// with valid/ready handshake and saturating error counters.
`default_nettype none

module hamming_dec #(
  parameter int k = 4,
  parameter int m = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [k+m-1:0]   cin,
  input  logic             cvld,
  output logic             crdy,
  output logic [k-1:0]     dout,
  output logic             dvld,
  input  logic             drdy,
  output logic [m-1:0]     syn,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [15:0]      corr_cnt,
  output logic [15:0]      uncorr_cnt
);

  localparam int N = k + m;

  // Codeword position of data bit j: the j-th position p whose p+1 is not a power of two.
  function automatic int data_pos(int j);
    int c   = 0;
    int pos = 0;
    for (int p = 0; p < N; p++) begin
      if (((p + 1) & p) != 0) begin
        if (c == j) pos = p;
        c++;
      end
    end
    return pos;
  endfunction

  function automatic logic [N-1:0] cover_mask(int i);
    logic [N-1:0] r = '0;
    for (int p = 0; p < N; p++) begin
      if ((((p + 1) >> i) & 1) != 0) r = r | (N'(1) << p);
    end
    return r;
  endfunction

  logic [N-1:0] w_placed;
  logic [m-1:0] w_syn;

  for (genvar j = 0; j < k; j++) begin : g_place_data
    localparam int P = data_pos(j);
    assign w_placed[P] = cin[j];
  end

  for (genvar i = 0; i < m; i++) begin : g_place_par
    assign w_placed[(1 << i) - 1] = cin[k + i];
  end

  // Each parity position 2**i-1 is covered only by its own mask, so it folds into the XOR.
  for (genvar i = 0; i < m; i++) begin : g_syn
    localparam logic [N-1:0] MASK = cover_mask(i);
    assign w_syn[i] = ^(w_placed & MASK);
  end

  logic         adv;
  logic         s1_vld_q;
  logic [N-1:0] s1_cin_q;
  logic [m-1:0] s1_syn_q;
  logic         dvld_q;
  logic [k-1:0] dout_q;
  logic [k-1:0] dout_d;
  logic [m-1:0] syn_q;
  logic         corr_q;
  logic         corr_d;
  logic         uncorr_q;
  logic         uncorr_d;
  logic [15:0]  corr_cnt_q;
  logic [15:0]  corr_cnt_d;
  logic [15:0]  uncorr_cnt_q;
  logic [15:0]  uncorr_cnt_d;
  logic         w_syn_zero;
  logic         w_syn_pow2;
  logic         w_syn_inrange;
  logic         w_hs;

  assign adv = !dvld_q || drdy;
  assign w_hs = dvld_q && drdy;

  assign w_syn_zero    = (s1_syn_q == '0);
  assign w_syn_pow2    = !w_syn_zero && ((s1_syn_q & (s1_syn_q - m'(1))) == '0);
  assign w_syn_inrange = (int'(s1_syn_q) <= N);

  // A syndrome matching a data position is never a power of two and always in range.
  for (genvar j = 0; j < k; j++) begin : g_fix
    localparam logic [m-1:0] SYNJ = m'(data_pos(j) + 1);
    assign dout_d[j] = s1_cin_q[j] ^ (s1_syn_q == SYNJ);
  end

  assign corr_d   = s1_vld_q && !w_syn_zero && (w_syn_pow2 || w_syn_inrange);
  assign uncorr_d = s1_vld_q && !w_syn_zero && !w_syn_pow2 && !w_syn_inrange;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_cin_q <= '0;
      s1_syn_q <= '0;
      dvld_q   <= 1'b0;
      dout_q   <= '0;
      syn_q    <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q <= cvld;
      s1_cin_q <= cin;
      s1_syn_q <= w_syn;
      dvld_q   <= s1_vld_q;
      dout_q   <= dout_d;
      syn_q    <= s1_syn_q;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (w_hs && corr_q && (corr_cnt_q != 16'hFFFF))
      corr_cnt_d = corr_cnt_q + 16'd1;
    if (w_hs && uncorr_q && (uncorr_cnt_q != 16'hFFFF))
      uncorr_cnt_d = uncorr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign crdy       = adv;
  assign dout       = dout_q;
  assign dvld       = dvld_q;
  assign syn        = syn_q;
  assign err_corr   = corr_q;
  assign err_uncorr = uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_dec.sv
// tb_hamming_dec: table-driven and scoreboard checks of hamming_dec at
// k=4,m=3 and k=3,m=3.
`default_nettype none

module tb_hamming_dec;

  typedef struct {
    logic [6:0] cin;
    logic [3:0] dout;
    logic [2:0] syn;
    bit         corr;
    bit         uncorr;
  } vec_t;

  typedef struct {
    logic [3:0] dout;
    logic [2:0] syn;
    bit         corr;
    bit         uncorr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [6:0]  cin = '0;
  logic        cvld = 1'b0;
  logic        drdy = 1'b1;
  logic        crdy, dvld, err_corr, err_uncorr;
  logic [3:0]  dout;
  logic [2:0]  syn;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic [5:0]  cin3 = '0;
  logic        cvld3 = 1'b0;
  logic        drdy3 = 1'b1;
  logic        crdy3, dvld3, err_corr3, err_uncorr3;
  logic [2:0]  dout3;
  logic [2:0]  syn3;
  logic [15:0] corr_cnt3, uncorr_cnt3;

  hamming_dec #(.k(4), .m(3)) u_dut (
    .clk(clk), .rst(rst), .cin(cin), .cvld(cvld), .crdy(crdy),
    .dout(dout), .dvld(dvld), .drdy(drdy), .syn(syn),
    .err_corr(err_corr), .err_uncorr(err_uncorr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_dec #(.k(3), .m(3)) u_dut3 (
    .clk(clk), .rst(rst), .cin(cin3), .cvld(cvld3), .crdy(crdy3),
    .dout(dout3), .dvld(dvld3), .drdy(drdy3), .syn(syn3),
    .err_corr(err_corr3), .err_uncorr(err_uncorr3),
    .corr_cnt(corr_cnt3), .uncorr_cnt(uncorr_cnt3)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q4[$];
  exp_t q3[$];
  int   exp_corr4 = 0, exp_uncorr4 = 0;
  int   exp_corr3 = 0, exp_uncorr3 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [2:0] p;
    p[0] = d[0] ^ d[1] ^ d[3];
    p[1] = d[0] ^ d[2] ^ d[3];
    p[2] = d[1] ^ d[2] ^ d[3];
    return {p, d};
  endfunction

  // Placed position -> cin bit index for k=4,m=3.
  function automatic int pos2cin(input int p);
    case (p)
      0: return 4;
      1: return 5;
      2: return 0;
      3: return 6;
      4: return 1;
      5: return 2;
      default: return 3;
    endcase
  endfunction

  // Scoreboard monitors: sample on the falling edge, pop on handshake.
  exp_t       e4, e3;
  logic [3:0] pdout;
  logic [2:0] psyn;
  bit         pstall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        chk("hold_dvld", 32'(dvld), 32'd1);
        chk("hold_dout", 32'(dout), 32'(pdout));
        chk("hold_syn",  32'(syn),  32'(psyn));
      end
      if (dvld && !drdy) chk("crdy_stall", 32'(crdy), 32'd0);
      if (dvld && drdy) begin
        if (q4.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_word: got dout %0h, want no output", dout);
        end else begin
          e4 = q4.pop_front();
          chk("dout",   32'(dout),       32'(e4.dout));
          chk("syn",    32'(syn),        32'(e4.syn));
          chk("corr",   32'(err_corr),   32'(e4.corr));
          chk("uncorr", 32'(err_uncorr), 32'(e4.uncorr));
          if (e4.corr)   exp_corr4++;
          if (e4.uncorr) exp_uncorr4++;
        end
      end
      pstall = dvld && !drdy;
      pdout  = dout;
      psyn   = syn;
    end
  end

  always @(negedge clk) begin
    if (!rst && dvld3 && drdy3) begin
      if (q3.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL extra_word3: got dout %0h, want no output", dout3);
      end else begin
        e3 = q3.pop_front();
        chk("dout3",   32'(dout3),       32'(e3.dout[2:0]));
        chk("syn3",    32'(syn3),        32'(e3.syn));
        chk("corr3",   32'(err_corr3),   32'(e3.corr));
        chk("uncorr3", 32'(err_uncorr3), 32'(e3.uncorr));
        if (e3.corr)   exp_corr3++;
        if (e3.uncorr) exp_uncorr3++;
      end
    end
  end

  task automatic send4(input logic [6:0] w, input exp_t e);
    int t = 0;
    cin  = w;
    cvld = 1'b1;
    forever begin
      @(negedge clk);
      if (crdy) break;
      t++;
      if (t > 50) begin
        n_vec++; n_bad++;
        $display("FAIL send_timeout: got crdy 0, want 1");
        cvld = 1'b0;
        return;
      end
    end
    q4.push_back(e);
    @(posedge clk);
    #1 cvld = 1'b0;
  endtask

  task automatic send3(input logic [5:0] w, input exp_t e);
    int t = 0;
    cin3  = w;
    cvld3 = 1'b1;
    forever begin
      @(negedge clk);
      if (crdy3) break;
      t++;
      if (t > 50) begin
        n_vec++; n_bad++;
        $display("FAIL send3_timeout: got crdy 0, want 1");
        cvld3 = 1'b0;
        return;
      end
    end
    q3.push_back(e);
    @(posedge clk);
    #1 cvld3 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q4.size() != 0 || q3.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: got %0d words outstanding, want 0", q4.size() + q3.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  vec_t       tv[10];
  exp_t       ex;
  logic [3:0] rd;
  logic [6:0] rcode;
  int         rq;
  bit         rnd_done;

  initial begin
    tv[0] = '{7'b0011011, 4'b1011, 3'b000, 1'b0, 1'b0};
    tv[1] = '{7'b0011111, 4'b1011, 3'b110, 1'b1, 1'b0};
    tv[2] = '{7'b0111011, 4'b1011, 3'b010, 1'b1, 1'b0};
    tv[3] = '{7'b0011010, 4'b1011, 3'b011, 1'b1, 1'b0};
    tv[4] = '{7'b0010011, 4'b1011, 3'b111, 1'b1, 1'b0};
    tv[5] = '{7'b0001011, 4'b1011, 3'b001, 1'b1, 1'b0};
    tv[6] = '{7'b1011011, 4'b1011, 3'b100, 1'b1, 1'b0};
    tv[7] = '{7'b0000000, 4'b0000, 3'b000, 1'b0, 1'b0};
    tv[8] = '{7'b1111101, 4'b1111, 3'b101, 1'b1, 1'b0};
    tv[9] = '{7'b0011000, 4'b1100, 3'b110, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dvld", 32'(dvld), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_syn",  32'(syn),  32'd0);
    chk("rst_flags", 32'({err_corr, err_uncorr}), 32'd0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    chk("rst_crdy", 32'(crdy), 32'd1);

    // First word accepted on the first edge after release, visible two edges later
    rst  = 1'b0;
    cin  = 7'b0011011;
    cvld = 1'b1;
    ex = '{4'b1011, 3'b000, 1'b0, 1'b0};
    q4.push_back(ex);
    @(posedge clk);
    #1 cvld = 1'b0;
    chk("lat_edge1_dvld", 32'(dvld), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_edge2_dvld", 32'(dvld), 32'd1);
    chk("lat_edge2_dout", 32'(dout), 32'hB);

    for (int i = 0; i < 10; i++) begin
      ex = '{tv[i].dout, tv[i].syn, tv[i].corr, tv[i].uncorr};
      send4(tv[i].cin, ex);
    end
    drain();
    chk("corr_cnt_table",   32'(corr_cnt),   32'(exp_corr4));
    chk("uncorr_cnt_table", 32'(uncorr_cnt), 32'(exp_uncorr4));

    // k=3,m=3: clean, data[2] error, out-of-range syndrome
    ex = '{4'b0001, 3'b000, 1'b0, 1'b0}; send3(6'b011001, ex);
    ex = '{4'b0001, 3'b110, 1'b1, 1'b0}; send3(6'b011101, ex);
    ex = '{4'b0001, 3'b111, 1'b0, 1'b1}; send3(6'b100001, ex);
    drain();
    chk("corr_cnt3",   32'(corr_cnt3),   32'd1);
    chk("uncorr_cnt3", 32'(uncorr_cnt3), 32'd1);

    // Back-to-back words with a 3-cycle downstream stall
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          ex = '{tv[i].dout, tv[i].syn, tv[i].corr, tv[i].uncorr};
          send4(tv[i].cin, ex);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #2 drdy = 1'b0;
        repeat (3) @(posedge clk);
        #2 drdy = 1'b1;
      end
    join
    drain();
    chk("corr_cnt_stall",   32'(corr_cnt),   32'(exp_corr4));
    chk("uncorr_cnt_stall", 32'(uncorr_cnt), 32'(exp_uncorr4));

    // Random single-bit errors with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          rd    = 4'($urandom);
          rq    = $urandom_range(0, 7);
          rcode = enc(rd);
          if (rq < 7) rcode[pos2cin(rq)] = ~rcode[pos2cin(rq)];
          ex = '{rd, (rq < 7) ? 3'(rq + 1) : 3'd0, rq < 7, 1'b0};
          send4(rcode, ex);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 drdy = ($urandom_range(0, 3) != 0);
        end
        drdy = 1'b1;
      end
    join
    drain();
    chk("corr_cnt_rand", 32'(corr_cnt), 32'(exp_corr4));

    // Reset with two words in flight
    ex = '{tv[1].dout, tv[1].syn, 1'b1, 1'b0}; send4(tv[1].cin, ex);
    ex = '{tv[2].dout, tv[2].syn, 1'b1, 1'b0}; send4(tv[2].cin, ex);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dvld", 32'(dvld), 32'd0);
    chk("midrst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    chk("midrst_crdy", 32'(crdy), 32'd1);
    q4.delete();
    exp_corr4   = 0;
    exp_uncorr4 = 0;
    @(negedge clk);
    rst  = 1'b0;
    cin  = tv[3].cin;
    cvld = 1'b1;
    ex = '{tv[3].dout, tv[3].syn, 1'b1, 1'b0};
    q4.push_back(ex);
    @(posedge clk);
    #1 cvld = 1'b0;
    chk("post_rst_edge1_dvld", 32'(dvld), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_edge2_dvld", 32'(dvld), 32'd1);
    chk("post_rst_edge2_dout", 32'(dout), 32'hB);
    drain();
    chk("post_rst_corr_cnt", 32'(corr_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
